flash_sample_controller: RTL and testbench
==========================================

FLASH_SAMPLE_CONTROLLER -- requirements
Module: flash_sample_controller

Interface
REQ-001 Parameter START_ADDR, default 23'h000000, first 32-bit word address of the audio region.
REQ-002 Parameter END_ADDR, default 23'h07FFFF, last 32-bit word address of the audio region (END_ADDR > START_ADDR).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 clr_n  in  1  asynchronous, active-low reset.
REQ-005 sample_tick  in  1  sample-rate pulse, already synchronized into clk, exactly one clk wide.
REQ-006 play  in  1  level; 1 = play, 0 = pause.
REQ-007 direction  in  1  level; 1 = forward, 0 = reverse.
REQ-008 restart  in  1  one-cycle pulse; return to start of region.
REQ-009 flash_read  out  1  Avalon-MM read request.
REQ-010 flash_address  out  23  word address of the current read.
REQ-011 flash_waitrequest  in  1  slave stall; request held while high.
REQ-012 flash_readdata  in  32  returned word.
REQ-013 flash_readdatavalid  in  1  readdata qualifier.
REQ-014 audio_sample  out  16  current sample, held between updates.
REQ-015 sample_valid  out  1  one-cycle pulse when audio_sample updates.
REQ-016 busy  out  1  high while a flash transaction is outstanding.
REQ-017 overrun  out  1  sticky; a tick arrived while busy.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT_DATA, OUT_FIRST, WAIT_TICK2, OUT_SECOND.
REQ-019 IDLE: sample_tick with play=1 and restart=0 -> REQ next cycle; direction latched into dir_q on this edge.
REQ-020 REQ: flash_read=1 with stable flash_address; leave to WAIT_DATA on the first edge where flash_waitrequest=0.
REQ-021 WAIT_DATA: flash_read=0; on flash_readdatavalid=1, latch flash_readdata into word register, go to OUT_FIRST.
REQ-022 OUT_FIRST: audio_sample <= word[15:0] if dir_q=1, else word[31:16]; sample_valid=1 for exactly this one cycle; go to WAIT_TICK2.
REQ-023 WAIT_TICK2: sample_tick with play=1 and restart=0 -> OUT_SECOND.
REQ-024 OUT_SECOND: audio_sample <= the other half; sample_valid=1 for one cycle; address step applied; go to IDLE.
REQ-025 Address step: dir_q=1 -> +1, END_ADDR wraps to START_ADDR; dir_q=0 -> -1, START_ADDR wraps to END_ADDR; no other arithmetic, 23-bit width.
REQ-026 busy SHALL equal 1 in REQ and WAIT_DATA only.
REQ-027 Latency: tick in IDLE at edge N -> flash_read=1 after edge N; readdatavalid at edge M -> sample_valid=1 after edge M, for one cycle.
REQ-028 sample_tick in REQ, WAIT_DATA, OUT_FIRST or OUT_SECOND SHALL be ignored for sequencing; in REQ or WAIT_DATA it SHALL also set overrun.
REQ-029 play=0: ticks in IDLE/WAIT_TICK2 ignored; an outstanding transaction SHALL complete and OUT_FIRST still fire.
REQ-030 restart in IDLE or WAIT_TICK2: flash_address <= START_ADDR if direction=1, else END_ADDR; overrun cleared; state -> IDLE; takes priority over a simultaneous tick, which is dropped.
REQ-031 restart in REQ, WAIT_DATA, OUT_FIRST or OUT_SECOND SHALL be held pending and applied on the first cycle in IDLE, overriding the address step of REQ-024.
REQ-032 direction changes SHALL take effect only at the next IDLE->REQ latch.

Reset
REQ-033 clr_n=0 SHALL asynchronously force: state IDLE, flash_read 0, flash_address START_ADDR, audio_sample 16'h0000, sample_valid 0, busy 0, overrun 0, pending restart 0, dir_q 1.
REQ-034 Reset mid-transaction SHALL abandon it; a late flash_readdatavalid after release in IDLE SHALL be ignored.

Verification
REQ-035 Forward: address 0, readdata 32'hBBBBAAAA, waitrequest 2 cycles -> sample AAAA, next tick BBBB, flash_address becomes 1.
REQ-036 Reverse wrap: direction=0, address START_ADDR, data 32'h12345678 -> 1234 then 5678, flash_address becomes END_ADDR.
REQ-037 Forward wrap: address END_ADDR, two ticks -> flash_address becomes START_ADDR.
REQ-038 Overrun: tick during WAIT_DATA -> overrun=1, no extra read; restart in IDLE -> overrun=0, address START_ADDR.
REQ-039 Pause: play=0 in WAIT_TICK2 with 3 ticks -> no sample_valid; play=1 plus tick -> second half output.
REQ-040 Reset: clr_n low during REQ -> flash_read=0 immediately, all outputs at REQ-033 values.

Source files
------------

// File: rtl/flash_sample_controller.sv
// Streams 16-bit audio samples out of a 32-bit Avalon-MM flash region: one word
// read per pair of sample ticks, low/high half order chosen by playback direction.
module flash_sample_controller #(
  parameter logic [22:0] START_ADDR = 23'h000000,
  parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        sample_tick,
  input  logic        play,
  input  logic        direction,
  input  logic        restart,
  output logic        flash_read,
  output logic [22:0] flash_address,
  input  logic        flash_waitrequest,
  input  logic [31:0] flash_readdata,
  input  logic        flash_readdatavalid,
  output logic [15:0] audio_sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_DATA, OUT_FIRST, WAIT_TICK2, OUT_SECOND
  } state_t;

  state_t      state;
  logic        dir_q;
  logic        restart_pend;
  logic [31:0] word;
  logic [22:0] restart_addr;
  logic [22:0] step_addr;
  logic        advance;

  always_comb begin
    restart_addr = direction ? START_ADDR : END_ADDR;
    advance      = sample_tick & play & ~restart;
    step_addr    = flash_address;
    if (dir_q) step_addr = (flash_address == END_ADDR)   ? START_ADDR : flash_address + 23'd1;
    else       step_addr = (flash_address == START_ADDR) ? END_ADDR   : flash_address - 23'd1;
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch below sees the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= IDLE;
      flash_read    <= 1'b0;
      flash_address <= START_ADDR;
      audio_sample  <= 16'h0000;
      sample_valid  <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      restart_pend  <= 1'b0;
      dir_q         <= 1'b1;
      word          <= 32'h0;
    end else begin
      sample_valid <= 1'b0;

      if (sample_tick && (state == REQ || state == WAIT_DATA))
        overrun <= 1'b1;
      // Restarts arriving mid-word wait until the sequencer is back in IDLE.
      if (restart && (state inside {REQ, WAIT_DATA, OUT_FIRST, OUT_SECOND}))
        restart_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (restart || restart_pend) begin
            flash_address <= restart_addr;
            overrun       <= 1'b0;
            restart_pend  <= 1'b0;
          end else if (advance) begin
            state      <= REQ;
            flash_read <= 1'b1;
            busy       <= 1'b1;
            dir_q      <= direction;
          end
        end
        REQ: begin
          if (!flash_waitrequest) begin
            state      <= WAIT_DATA;
            flash_read <= 1'b0;
          end
        end
        WAIT_DATA: begin
          // First half comes straight from the bus so it is visible in OUT_FIRST.
          if (flash_readdatavalid) begin
            word         <= flash_readdata;
            audio_sample <= dir_q ? flash_readdata[15:0] : flash_readdata[31:16];
            sample_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= OUT_FIRST;
          end
        end
        OUT_FIRST: state <= WAIT_TICK2;
        WAIT_TICK2: begin
          if (restart) begin
            flash_address <= restart_addr;
            overrun       <= 1'b0;
            restart_pend  <= 1'b0;
            state         <= IDLE;
          end else if (advance) begin
            audio_sample <= dir_q ? word[31:16] : word[15:0];
            sample_valid <= 1'b1;
            state        <= OUT_SECOND;
          end
        end
        OUT_SECOND: begin
          flash_address <= step_addr;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sample_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a phase-level behavioural model.
module tb_flash_sample_controller;

  localparam logic [22:0] S = 23'h000010;
  localparam logic [22:0] E = 23'h000013;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        sample_tick = 1'b0, play = 1'b0, direction = 1'b1, restart = 1'b0;
  logic        flash_read, flash_waitrequest = 1'b0, flash_readdatavalid = 1'b0;
  logic [22:0] flash_address;
  logic [31:0] flash_readdata = 32'h0;
  logic [15:0] audio_sample;
  logic        sample_valid, busy, overrun;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  flash_sample_controller #(.START_ADDR(S), .END_ADDR(E)) dut (
    .clk(clk), .clr_n(clr_n), .sample_tick(sample_tick), .play(play),
    .direction(direction), .restart(restart), .flash_read(flash_read),
    .flash_address(flash_address), .flash_waitrequest(flash_waitrequest),
    .flash_readdata(flash_readdata), .flash_readdatavalid(flash_readdatavalid),
    .audio_sample(audio_sample), .sample_valid(sample_valid), .busy(busy),
    .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- flash slave ----------------
  bit          use_rand = 1'b0, use_fixed = 1'b1;
  int          cfg_stall = 0, cfg_lat = 1;
  logic [31:0] fixed_data = 32'h0;
  int          stall_cnt = 0, rv_cnt = 0;
  int          rd_count = 0;

  always @(negedge clk) begin
    flash_readdatavalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        flash_readdatavalid = 1'b1;
        flash_readdata = use_fixed ? fixed_data : $urandom;
      end
    end
    if (flash_read) begin
      if (stall_cnt > 0) begin
        flash_waitrequest = 1'b1;
        stall_cnt--;
      end else begin
        flash_waitrequest = 1'b0;
        rv_cnt = use_rand ? $urandom_range(1, 4) : cfg_lat;
      end
    end else begin
      flash_waitrequest = 1'b0;
      stall_cnt = use_rand ? $urandom_range(0, 3) : cfg_stall;
    end
  end

  always @(posedge clk)
    if (clr_n && flash_read && !flash_waitrequest) rd_count++;

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 requesting, 2 awaiting data, 3 first half shown,
  // 4 awaiting second tick, 5 second half shown.
  int          m_ph = 0;
  logic [22:0] m_addr = S;
  logic [15:0] m_sample = 16'h0;
  logic [31:0] m_word = 32'h0;
  logic        m_ovr = 1'b0, m_pend = 1'b0, m_dir = 1'b1;

  function automatic logic [22:0] next_addr(input logic [22:0] a, input logic d);
    int n, off;
    n   = int'(E) - int'(S) + 1;
    off = int'(a) - int'(S);
    off = d ? (off + 1) % n : (off + n - 1) % n;
    return 23'(int'(S) + off);
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_ph = 0; m_addr = S; m_sample = 16'h0; m_ovr = 1'b0; m_pend = 1'b0; m_dir = 1'b1;
    end else begin
      if (sample_tick && (m_ph == 1 || m_ph == 2)) m_ovr = 1'b1;
      if (restart && (m_ph == 1 || m_ph == 2 || m_ph == 3 || m_ph == 5)) m_pend = 1'b1;
      case (m_ph)
        0: if (restart || m_pend) begin
             m_addr = direction ? S : E; m_ovr = 1'b0; m_pend = 1'b0;
           end else if (sample_tick && play) begin
             m_ph = 1; m_dir = direction;
           end
        1: if (!flash_waitrequest) m_ph = 2;
        2: if (flash_readdatavalid) begin
             m_word = flash_readdata;
             m_sample = m_dir ? m_word[15:0] : m_word[31:16];
             m_ph = 3;
           end
        3: m_ph = 4;
        4: if (restart) begin
             m_addr = direction ? S : E; m_ovr = 1'b0; m_pend = 1'b0; m_ph = 0;
           end else if (sample_tick && play) begin
             m_sample = m_dir ? m_word[31:16] : m_word[15:0];
             m_ph = 5;
           end
        default: begin m_addr = next_addr(m_addr, m_dir); m_ph = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    check("model flash_read", flash_read, m_ph == 1);
    check("model busy", busy, m_ph == 1 || m_ph == 2);
    check("model sample_valid", sample_valid, m_ph == 3 || m_ph == 5);
    check("model flash_address", flash_address, m_addr);
    check("model audio_sample", audio_sample, m_sample);
    check("model overrun", overrun, m_ovr);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int i;
    for (i = 0; i < 50; i++) begin
      if (sample_valid) break;
      @(negedge clk);
    end
    if (i == 50) check({name, " timeout"}, sample_valid, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_tick = 1'b0; restart = 1'b0;
    #2 clr_n = 1'b0;
    @(negedge clk);
    #2 clr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_restart(input logic dir);
    @(negedge clk) begin restart = 1'b1; direction = dir; end
    @(negedge clk) restart = 1'b0;
  endtask

  int rd_before;

  initial begin
    #12 clr_n = 1'b1;
    @(negedge clk);
    check("reset address", flash_address, S);
    check("reset sample", audio_sample, 16'h0000);
    check("reset overrun", overrun, 1'b0);

    // Forward read with two wait states.
    play = 1'b1; direction = 1'b1; cfg_stall = 2; cfg_lat = 2; fixed_data = 32'hBBBBAAAA;
    tick();
    wait_valid("fwd first");
    check("fwd first half", audio_sample, 16'hAAAA);
    tick();
    wait_valid("fwd second");
    check("fwd second half", audio_sample, 16'hBBBB);
    @(negedge clk);
    check("fwd address step", flash_address, 23'h000011);

    // Reverse from START wraps to END.
    do_reset();
    direction = 1'b0; cfg_stall = 0; fixed_data = 32'h12345678;
    tick();
    wait_valid("rev first");
    check("rev first half", audio_sample, 16'h1234);
    tick();
    wait_valid("rev second");
    check("rev second half", audio_sample, 16'h5678);
    @(negedge clk);
    check("rev wrap address", flash_address, 23'h000013);

    // Forward from END wraps to START; direction only latched at IDLE->REQ.
    direction = 1'b1;
    tick();
    wait_valid("fwrap first");
    direction = 1'b0;
    tick();
    wait_valid("fwrap second");
    @(negedge clk);
    check("fwd wrap address", flash_address, 23'h000010);

    // Overrun: tick during WAIT_DATA, then restart clears it.
    direction = 1'b1; cfg_stall = 0; cfg_lat = 3; fixed_data = 32'h00C0FFEE;
    rd_before = rd_count;
    tick();
    tick();
    check("overrun set", overrun, 1'b1);
    wait_valid("ovr first");
    check("no extra read", rd_count - rd_before, 1);
    tick();
    wait_valid("ovr second");
    @(negedge clk);
    check("ovr step address", flash_address, 23'h000011);
    pulse_restart(1'b1);
    check("overrun cleared", overrun, 1'b0);
    check("restart address", flash_address, 23'h000010);

    // Pause while waiting for the second tick.
    fixed_data = 32'hCAFEF00D; cfg_lat = 1;
    tick();
    wait_valid("pause first");
    check("pause first half", audio_sample, 16'hF00D);
    play = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("pause no valid", sample_valid, 1'b0);
      @(negedge clk);
      check("pause no valid gap", sample_valid, 1'b0);
    end
    play = 1'b1;
    tick();
    wait_valid("pause second");
    check("pause second half", audio_sample, 16'hCAFE);

    // Reset asserted during REQ.
    @(negedge clk);
    cfg_stall = 5;
    @(negedge clk);
    tick();
    check("req before reset", flash_read, 1'b1);
    #2 clr_n = 1'b0;
    #1;
    check("reset flash_read", flash_read, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset valid", sample_valid, 1'b0);
    check("reset addr mid", flash_address, S);
    check("reset sample mid", audio_sample, 16'h0000);
    @(negedge clk) #2 clr_n = 1'b1;

    // Reset during WAIT_DATA; the late readdatavalid must be ignored.
    cfg_stall = 0; cfg_lat = 4;
    @(negedge clk);
    tick();
    @(negedge clk);
    #2 clr_n = 1'b0;
    @(negedge clk) #2 clr_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("late rdv ignored", sample_valid, 1'b0);
    end

    // Randomized traffic against the model.
    use_rand = 1'b1; use_fixed = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      sample_tick = !sample_tick && ($urandom_range(0, 3) == 0);
      play = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) direction = 1'($urandom_range(0, 1));
      restart = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2 clr_n = 1'b0;
        #6 clr_n = 1'b1;
      end
    end
    @(negedge clk);
    sample_tick = 1'b0; restart = 1'b0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
